// File: rtl/smem_tester.sv
// Self-test PerInt master: writes SEED^addr over [BASE, BASE+SIZE), reads it back and counts mismatches.
// Optional SMEM_TESTER_INVPASS_EN adds a second pass with the inverted pattern.
`timescale 1ns/1ps
module smem_tester #(
  parameter int unsigned  ARCHBITSZ = 16,
  parameter int unsigned  SIZE      = 2,
  parameter int unsigned  BASE      = 0,
  parameter logic [255:0] SEED      = 256'h5A5A,
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   rst_i,
  input  logic                   clk_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ARCHBITSZ-1:0]   errcnt_o,
  output logic [ADDRBITSZ-1:0]   erraddr_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int unsigned            PADW    = ARCHBITSZ - ADDRBITSZ;
  localparam logic [ADDRBITSZ-1:0]   FIRST_A = ADDRBITSZ'(BASE);
  localparam logic [ADDRBITSZ-1:0]   LAST_A  = ADDRBITSZ'(BASE + SIZE - 1);
  localparam logic [ARCHBITSZ-1:0]   SEED_W  = SEED[ARCHBITSZ-1:0];
  localparam logic [ARCHBITSZ-1:0]   ONES    = '1;
  localparam logic [1:0]             OP_NOOP = 2'b00;
  localparam logic [1:0]             OP_WR   = 2'b01;
  localparam logic [1:0]             OP_RD   = 2'b10;

  state_t                 state_q, state_d;
  logic [ADDRBITSZ-1:0]   addr_q, addr_d;
  logic                   pend_q, pend_d;
  logic [ADDRBITSZ-1:0]   pend_addr_q, pend_addr_d;
  logic [ARCHBITSZ-1:0]   errcnt_q, errcnt_d;
  logic [ADDRBITSZ-1:0]   erraddr_q, erraddr_d;
  logic                   cmp_en;
  logic                   inv;

`ifdef SMEM_TESTER_INVPASS_EN
  logic inv_q, inv_d;
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  function automatic logic [ARCHBITSZ-1:0] pattern(input logic [ADDRBITSZ-1:0] a, input logic inv_i);
    pattern = SEED_W ^ {{PADW{1'b0}}, a} ^ {ARCHBITSZ{inv_i}};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      errcnt_q    <= '0;
      erraddr_q   <= '0;
`ifdef SMEM_TESTER_INVPASS_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      errcnt_q    <= errcnt_d;
      erraddr_q   <= erraddr_d;
`ifdef SMEM_TESTER_INVPASS_EN
      inv_q       <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    errcnt_d    = errcnt_q;
    erraddr_d   = erraddr_q;
    cmp_en      = 1'b0;
`ifdef SMEM_TESTER_INVPASS_EN
    inv_d       = inv_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_WRITE;
          addr_d    = FIRST_A;
          pend_d    = 1'b0;
          errcnt_d  = '0;
          erraddr_d = '0;
`ifdef SMEM_TESTER_INVPASS_EN
          inv_d     = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        if (pi1_rdy_i) begin
          if (addr_q == LAST_A) begin
            state_d = S_READ;
            addr_d  = FIRST_A;
          end else begin
            addr_d = addr_q + ADDRBITSZ'(1);
          end
        end
      end
      S_READ: begin
        // a ready edge both returns the previous read and accepts the current one
        if (pi1_rdy_i) begin
          cmp_en      = 1'b1;
          pend_d      = 1'b1;
          pend_addr_d = addr_q;
          if (addr_q == LAST_A) state_d = S_DRAIN;
          else                  addr_d  = addr_q + ADDRBITSZ'(1);
        end
      end
      S_DRAIN: begin
        if (pi1_rdy_i) begin
          cmp_en = 1'b1;
          pend_d = 1'b0;
`ifdef SMEM_TESTER_INVPASS_EN
          if (!inv_q) begin
            state_d = S_WRITE;
            addr_d  = FIRST_A;
            inv_d   = 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmp_en && pend_q && (pi1_data_i != pattern(pend_addr_q, inv))) begin
      if (errcnt_q != ONES) errcnt_d = errcnt_q + ARCHBITSZ'(1);
      if (errcnt_q == '0)   erraddr_d = pend_addr_q;
    end
  end

  always_comb begin
    pi1_op_o   = OP_NOOP;
    pi1_data_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    pass_o     = 1'b0;
    case (state_q)
      S_WRITE: begin
        pi1_op_o   = OP_WR;
        pi1_data_o = pattern(addr_q, inv);
        busy_o     = 1'b1;
      end
      S_READ: begin
        pi1_op_o = OP_RD;
        busy_o   = 1'b1;
      end
      S_DRAIN: busy_o = 1'b1;
      S_DONE: begin
        done_o = 1'b1;
        pass_o = (errcnt_q == '0);
      end
      default: ;
    endcase
  end

  assign pi1_addr_o = addr_q;
  assign pi1_sel_o  = '1;
  assign errcnt_o   = errcnt_q;
  assign erraddr_o  = erraddr_q;

endmodule

// File: tb/tb_smem_tester.sv
// Bench for smem_tester: delay-configurable fault-injecting slave, vector table, random faults, mid-run reset.
`timescale 1ns/1ps
module tb_smem_tester;
`ifdef SMEM_TESTER_INVPASS_EN
  localparam int S = 2;
  localparam int NPASS = 2;
`else
  localparam int S = 4;
  localparam int NPASS = 1;
`endif
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, pass_o;
  logic [15:0] errcnt_o;
  logic [14:0] erraddr_o;
  logic [1:0]  pi1_op_o;
  logic [14:0] pi1_addr_o;
  logic [15:0] pi1_data_o;
  logic [15:0] pi1_data_i;
  logic [1:0]  pi1_sel_o;
  logic        pi1_rdy_i;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  smem_tester #(.ARCHBITSZ(16), .SIZE(S), .BASE(0), .SEED(256'h5A5A)) dut (
    .rst_i(rst_i), .clk_i(clk), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .errcnt_o(errcnt_o), .erraddr_o(erraddr_o),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
    .pi1_data_i(pi1_data_i), .pi1_sel_o(pi1_sel_o), .pi1_rdy_i(pi1_rdy_i)
  );

  // ---------------- slave model with access delay and read-fault injection
  logic [15:0] mem [16];
  logic [15:0] mask [16];
  logic [15:0] wr_data_log [256];
  logic [14:0] wr_addr_log [256];
  int          wr_n = 0;
  int          cnt = 0;
  logic [15:0] rd_data = '0;
  int          mode_r = 0;
  int          delay_r = 0;

  function automatic logic [15:0] slave_ret(input logic [14:0] a, input logic [15:0] v);
    case (mode_r)
      1:       slave_ret = (a == 15'd2) ? 16'h0000 : v;
      2:       slave_ret = 16'h0000;
      3:       slave_ret = v ^ mask[a[3:0]];
      default: slave_ret = v;
    endcase
  endfunction

  assign pi1_rdy_i  = (cnt == 0);
  assign pi1_data_i = rd_data;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= 0;
      rd_data <= '0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end else if (pi1_op_o != 2'b00) begin
      cnt <= delay_r;
      if (pi1_op_o == 2'b01) begin
        mem[pi1_addr_o[3:0]]    <= pi1_data_o;
        wr_data_log[wr_n % 256] <= pi1_data_o;
        wr_addr_log[wr_n % 256] <= pi1_addr_o;
        wr_n                    <= wr_n + 1;
      end else begin
        rd_data <= slave_ret(pi1_addr_o, mem[pi1_addr_o[3:0]]);
      end
    end
  end

  // ---------------- protocol monitor: hold-until-accept, no RW, full byte enables
  logic [1:0]  p_op;
  logic [14:0] p_addr;
  logic [15:0] p_data;
  logic        p_rdy;
  bit          mon_v = 1'b0;
  int          proto_err = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      mon_v <= 1'b0;
    end else begin
      if ((mon_v && p_op != 2'b00 && !p_rdy &&
           (pi1_op_o != p_op || pi1_addr_o != p_addr || pi1_data_o != p_data)) ||
          pi1_op_o == 2'b11 || pi1_sel_o != 2'b11)
        proto_err <= proto_err + 1;
      mon_v  <= 1'b1;
      p_op   <= pi1_op_o;
      p_addr <= pi1_addr_o;
      p_data <= pi1_data_o;
      p_rdy  <= pi1_rdy_i;
    end
  end

  // ---------------- helpers
  function automatic logic [15:0] tb_pat(input int a, input int p);
    logic [15:0] av;
    av = 16'(a);
    tb_pat = (16'h5A5A ^ av) ^ ((p != 0) ? 16'hFFFF : 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_one(input string tag, input int mode, input int dly, input bit spam,
                         input logic [15:0] e_err, input logic [14:0] e_ea, input bit e_pass,
                         input int e_edges);
    int edges, w0, pe0, busy_bad, wbad, idx;
    mode_r  = mode;
    delay_r = dly;
    w0      = wr_n;
    pe0     = proto_err;
    busy_bad = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    edges = 0;
    while (!done_o && edges < LIMIT) begin
      if (!busy_o) busy_bad++;
      start_i = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start_i = 1'b0;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_edges"}, 32'(edges), 32'(e_edges));
    chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
    chk({tag, "_pass"}, 32'(pass_o), 32'(e_pass));
    chk({tag, "_errcnt"}, 32'(errcnt_o), 32'(e_err));
    chk({tag, "_erraddr"}, 32'(erraddr_o), 32'(e_ea));
    chk({tag, "_protocol"}, 32'(proto_err - pe0), 32'd0);
    chk({tag, "_nwrites"}, 32'(wr_n - w0), 32'(NPASS * S));
    wbad = 0;
    for (int i = 0; i < NPASS * S; i++) begin
      idx = (w0 + i) % 256;
      if (wr_data_log[idx] !== tb_pat(i % S, i / S) || wr_addr_log[idx] !== 15'(i % S)) wbad++;
    end
    chk({tag, "_wrdata"}, 32'(wbad), 32'd0);
  endtask

  typedef struct {
    int          mode;
    int          dly;
    bit          spam;
    logic [15:0] err;
    logic [14:0] ea;
    bit          pass;
    int          edges;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          wait_n, dly, e_err, e_ea, e_edges;
    bit          first;
    logic [15:0] v;

`ifdef SMEM_TESTER_INVPASS_EN
    vecs[0] = '{0, 0, 1'b0, 16'd0, 15'd0, 1'b1, 10};
    vecs[1] = '{0, 3, 1'b0, 16'd0, 15'd0, 1'b1, 34};
    vecs[2] = '{1, 0, 1'b0, 16'd0, 15'd0, 1'b1, 10};
    vecs[3] = '{2, 0, 1'b0, 16'd4, 15'd0, 1'b0, 10};
    vecs[4] = '{0, 1, 1'b1, 16'd0, 15'd0, 1'b1, 18};
    vecs[5] = '{2, 2, 1'b1, 16'd4, 15'd0, 1'b0, 26};
`else
    vecs[0] = '{0, 0, 1'b0, 16'd0, 15'd0, 1'b1, 9};
    vecs[1] = '{0, 3, 1'b0, 16'd0, 15'd0, 1'b1, 33};
    vecs[2] = '{1, 0, 1'b0, 16'd1, 15'd2, 1'b0, 9};
    vecs[3] = '{2, 0, 1'b0, 16'd4, 15'd0, 1'b0, 9};
    vecs[4] = '{0, 1, 1'b1, 16'd0, 15'd0, 1'b1, 17};
    vecs[5] = '{1, 2, 1'b1, 16'd1, 15'd2, 1'b0, 25};
`endif
    for (int a = 0; a < 16; a++) mask[a] = '0;

    // reset values while reset is held
    #12;
    chk("rst_op", 32'(pi1_op_o), 32'd0);
    chk("rst_addr", 32'(pi1_addr_o), 32'd0);
    chk("rst_data", 32'(pi1_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_errcnt", 32'(errcnt_o), 32'd0);
    chk("rst_erraddr", 32'(erraddr_o), 32'd0);
    chk("rst_sel", 32'(pi1_sel_o), 32'h3);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_op", 32'(pi1_op_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);

    // table-driven runs, back to back (each restart must clear the previous result)
    for (int i = 0; i < 6; i++)
      run_one($sformatf("vec%0d", i), vecs[i].mode, vecs[i].dly, vecs[i].spam,
              vecs[i].err, vecs[i].ea, vecs[i].pass, vecs[i].edges);

    // random read corruption checked against a pass/address-level model
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++)
        mask[a] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      dly     = $urandom_range(0, 3);
      e_err   = 0;
      e_ea    = 0;
      first   = 1'b1;
      for (int p = 0; p < NPASS; p++)
        for (int a = 0; a < S; a++) begin
          v = tb_pat(a, p);
          if ((v ^ mask[a]) != v) begin
            if (first) e_ea = a;
            first = 1'b0;
            if (e_err < 65535) e_err++;
          end
        end
      e_edges = NPASS * (2 * S * (dly + 1) + 1);
      run_one($sformatf("rnd%0d", r), 3, dly, 1'($urandom_range(0, 1)),
              16'(e_err), 15'(e_ea), (e_err == 0), e_edges);
    end

    // asynchronous reset in the middle of READ, then a clean rerun
    mode_r  = 2;
    delay_r = 1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_n = 0;
    while (!(pi1_op_o == 2'b10 && pi1_addr_o == 15'(S - 1)) && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    chk("mid_reached_read", 32'(wait_n < 500), 32'd1);
    chk("mid_errcnt_before", 32'(errcnt_o), 32'(S - 2));
    rst_i = 1'b1;
    #1;
    chk("mid_rst_op", 32'(pi1_op_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_errcnt", 32'(errcnt_o), 32'd0);
    chk("mid_rst_erraddr", 32'(erraddr_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_addr", 32'(pi1_addr_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    run_one("after_rst", 0, 0, 1'b0, 16'd0, 15'd0, 1'b1, NPASS * (2 * S + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smem_tester.md
Name: smem_tester

Overview:
PerInt master that sits directly upstream of a static-memory slave and exercises it.
- On a start pulse it writes a deterministic pattern across a word range, then reads the range back and compares.
- It reports pass/fail, a saturating error count and the first failing address.
- Used in simulation benches and on-chip self-test to qualify memory, including slaves configured with a non-zero access DELAY.

Parameters:
ARCHBITSZ, 16, data width in bits; one of 16/32/64/128/256. ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
SIZE, 2, number of words tested; must be >= 1 and <= 2**ADDRBITSZ - BASE.
BASE, 0, first word address tested.
SEED, 16'h5A5A, pattern seed; zero-extended or truncated to ARCHBITSZ.

Ports:
rst_i  input  1  asynchronous reset, active high
clk_i  input  1  clock
start_i  input  1  one-cycle pulse; starts a test when idle
busy_o  output  1  high while a test runs
done_o  output  1  high from test end until next start or reset
pass_o  output  1  valid when done_o; 1 = no mismatches
errcnt_o  output  ARCHBITSZ  mismatch count, saturates at all-ones
erraddr_o  output  ADDRBITSZ  word address of first mismatch
pi1_op_o  output  2  PerInt op: 00 NOOP, 01 WR, 10 RD, 11 RW (RW never issued)
pi1_addr_o  output  ADDRBITSZ  word address
pi1_data_o  output  ARCHBITSZ  write data
pi1_data_i  input  ARCHBITSZ  read data
pi1_sel_o  output  ARCHBITSZ/8  byte enables; always all ones
pi1_rdy_i  input  1  slave ready

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included): state IDLE; pi1_op_o=NOOP; pi1_addr_o=0; pi1_data_o=0; busy_o=0; done_o=0; pass_o=0; errcnt_o=0; erraddr_o=0. Any outstanding slave access is abandoned.
- Pattern: P(a) = SEED ^ a, where a is the word address zero-extended to ARCHBITSZ.
- Acceptance rule: an op is accepted at a rising edge where pi1_op_o != NOOP and pi1_rdy_i=1.
  - pi1_op_o, pi1_addr_o and pi1_data_o are held stable until acceptance.
- Read-data rule: data for an accepted RD is valid on pi1_data_i at the first later rising edge with pi1_rdy_i=1. That edge may also accept the next op (pipelined).
- IDLE:
  - start_i=1 -> WRITE, with addr=BASE, busy_o=1, done_o=0, errcnt_o=0, erraddr_o=0.
  - pi1_op_o=NOOP.
- WRITE:
  - pi1_op_o=WR, data=P(addr).
  - On acceptance: if addr == BASE+SIZE-1, go to READ with addr=BASE; else addr+1.
- READ:
  - pi1_op_o=RD.
  - On each edge with pi1_rdy_i=1: if a read is pending, compare pi1_data_i with P(pending addr).
  - On acceptance: record addr as pending. If last addr, go to DRAIN (op=NOOP); else addr+1.
- DRAIN:
  - On first edge with pi1_rdy_i=1: compare the last pending read, then go to DONE.
- DONE: busy_o=0, done_o=1, pass_o=(errcnt_o==0). start_i=1 restarts the test as from IDLE.
- Compare: a mismatch increments errcnt_o, saturating at all-ones. On the first mismatch only, erraddr_o captures that address.
- start_i in WRITE/READ/DRAIN is ignored.
- Throughput with an always-ready slave: SIZE write cycles + SIZE read cycles + 1 drain cycle. Total 2*SIZE+1 edges from leaving IDLE to DONE.
- SIZE=1: WRITE goes to READ after one accept; READ goes to DRAIN after one accept.
- Address arithmetic is ADDRBITSZ wide; no wrap occurs under the SIZE constraint.

Optional Feature:
SMEM_TESTER_INVPASS_EN
- Defined: after DRAIN of the first pass, a second WRITE/READ/DRAIN pass runs over the same range with pattern ~P(a).
  - errcnt_o accumulates across both passes.
  - erraddr_o keeps the first mismatch of either pass.
  - Total edges with an always-ready slave = 4*SIZE+2.
- Undefined: single pass only; no inverted-pattern logic is instantiated.

Test Plan:
- ARCHBITSZ=16, SIZE=4, BASE=0, SEED=16'h5A5A, ideal slave with DELAY=0, pulse start_i -> writes 5A5A,5A5B,5A58,5A59 to addrs 0..3; done_o after 9 edges; pass_o=1; errcnt_o=0.
- Same setup, slave DELAY=3 -> each op held until rdy; identical write data; pass_o=1; busy_o low only at the end.
- Slave forces addr 2 read to 0000 -> errcnt_o=1, erraddr_o=2, pass_o=0.
- Slave returns 0 for all reads -> errcnt_o=4, erraddr_o=0 (first mismatch).
- Assert rst_i during READ at addr 1 -> same-cycle pi1_op_o=NOOP, busy_o=0, errcnt_o=0; a new start_i then completes with pass_o=1.
- With SMEM_TESTER_INVPASS_EN, SIZE=2 -> second-pass writes A5A5, A5A4; done_o after 10 edges; pass_o=1.
